// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the digit-serial adder.
//   state_t : control FSM encoding (IDLE / RUN / DONE)
//   cnt_w() : width of a counter that must be able to hold the value n
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter width; clamp to 1 so a degenerate N still yields a legal vector.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple-carry adder built from a chain
// of full-adder cells.
//   a, b : DIGIT-bit operand slices
//   ci   : carry into bit 0
//   s    : DIGIT-bit sum slice
//   co   : carry out of bit DIGIT-1
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial a + b + cin, DIGIT bits per clock over
// N = WIDTH/DIGIT cycles, with valid/ready handshakes on both sides.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin [, sub])
//   out_valid/out_ready : result handshake (sum, cout [, overflow])
// Optional feature macro SERIAL_ADDER_SUB_EN: adds 'sub' (computes a + ~b + cin)
// and 'overflow' (two's-complement signed overflow of the result).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
  output logic             overflow,
`endif
  output logic             cout
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_w(N);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
  end

  state_t            state, nxt;
  logic [WIDTH-1:0]  a_sr, b_sr;
  logic              carry;
  logic [CW-1:0]     cnt;
  logic [DIGIT-1:0]  ds;
  logic              dco;
  logic              last;
  logic [WIDTH-1:0]  sum_nxt;
  logic [WIDTH-1:0]  b_in;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_in = sub ? ~b : b;
`else
  assign b_in = b;
`endif

  digit_adder #(.DIGIT(DIGIT)) u_dig (
    .a  (a_sr[DIGIT-1:0]),
    .b  (b_sr[DIGIT-1:0]),
    .ci (carry),
    .s  (ds),
    .co (dco)
  );

  // Result digits enter at the MSB end so after N steps the LSB digit sits at bit 0.
  if (DIGIT == WIDTH) begin : g_sum_full
    assign sum_nxt = ds;
  end else begin : g_sum_shift
    assign sum_nxt = {ds, sum[WIDTH-1:DIGIT]};
  end

  assign last      = (cnt == CW'(N - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid)  nxt = RUN;
      RUN:     if (last)      nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default:                nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr  <= a;
          b_sr  <= b_in;
          carry <= cin;
          cnt   <= '0;
        end
        RUN: begin
          sum   <= sum_nxt;
          a_sr  <= a_sr >> DIGIT;
          b_sr  <= b_sr >> DIGIT;
          carry <= dco;
          cnt   <= cnt + CW'(1);
          if (last) begin
            cout <= dco;
`ifdef SERIAL_ADDER_SUB_EN
            // Carry into the MSB is recovered as s ^ a ^ b of that bit.
            overflow <= ds[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ dco;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: three serial_adder instances (DIGIT = 1, 4, 8 at WIDTH = 8)
// driven by per-scenario tasks; expected results come from a behavioural model
// pushed to a scoreboard queue at accept time and popped at out_valid.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid [3];
  logic       in_ready [3];
  logic       cin      [3];
  logic       out_valid[3];
  logic       out_ready[3];
  logic       cout     [3];
  logic [7:0] a        [3];
  logic [7:0] b        [3];
  logic [7:0] sum      [3];
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub      [3];
  logic       overflow [3];
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
  } exp_t;

  exp_t sb[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 1 : (g == 1) ? 4 : 8;
    serial_adder #(.WIDTH(8), .DIGIT(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a[g]),
      .b         (b[g]),
      .cin       (cin[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .sum       (sum[g]),
`ifdef SERIAL_ADDER_SUB_EN
      .sub       (sub[g]),
      .overflow  (overflow[g]),
`endif
      .cout      (cout[g])
    );
  end

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                 input logic ci, input logic s_);
    exp_t       m;
    logic [7:0] yy;
    logic [8:0] r;
    yy  = s_ ? ~y : y;
    r   = {1'b0, x} + {1'b0, yy} + {8'd0, ci};
    m.s = r[7:0];
    m.c = r[8];
    m.v = (x[7] == yy[7]) && (r[7] != x[7]);
    return m;
  endfunction

  // One full transaction on instance d; optional back-pressure of 'stall' cycles.
  task automatic run_op(input int d, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input logic s_, input int lat, input int stall);
    exp_t       e;
    int         cyc;
    logic [7:0] hs;
    logic       hc;
    logic       s_eff;
`ifdef SERIAL_ADDER_SUB_EN
    s_eff = s_;
`else
    s_eff = 1'b0;
`endif
    @(negedge clk);
    a[d] = x; b[d] = y; cin[d] = ci; in_valid[d] = 1'b1; out_ready[d] = (stall == 0);
`ifdef SERIAL_ADDER_SUB_EN
    sub[d] = s_eff;
`endif
    tests++;
    if (in_ready[d] !== 1'b1) begin
      fails++; $display("FAIL in_ready_idle d=%0d got=%b exp=1", d, in_ready[d]);
    end
    sb.push_back(model(x, y, ci, s_eff));
    @(negedge clk);
    in_valid[d] = 1'b0;
    cyc = 0;
    while (out_valid[d] !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (cyc != lat) begin
      fails++; $display("FAIL latency d=%0d got=%0d exp=%0d", d, cyc, lat);
    end
    if (stall > 0) begin
      hs = sum[d]; hc = cout[d];
      for (int i = 0; i < stall; i++) begin
        in_valid[d] = 1'b1; a[d] = ~x; b[d] = ~y;
        @(negedge clk);
        tests++;
        if (sum[d] !== hs || cout[d] !== hc || in_ready[d] !== 1'b0 || out_valid[d] !== 1'b1) begin
          fails++;
          $display("FAIL stall d=%0d cyc=%0d sum=%h/%h cout=%b/%b in_ready=%b out_valid=%b exp in_ready=0 out_valid=1",
                   d, i, sum[d], hs, cout[d], hc, in_ready[d], out_valid[d]);
        end
      end
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
    end
    e = sb.pop_front();
    tests++;
    if (sum[d] !== e.s || cout[d] !== e.c) begin
      fails++;
      $display("FAIL result d=%0d a=%h b=%h cin=%b got=%b_%h exp=%b_%h", d, x, y, ci, cout[d], sum[d], e.c, e.s);
    end
`ifdef SERIAL_ADDER_SUB_EN
    tests++;
    if (overflow[d] !== e.v) begin
      fails++; $display("FAIL overflow d=%0d a=%h b=%h got=%b exp=%b", d, x, y, overflow[d], e.v);
    end
`endif
    @(negedge clk);
    tests++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
      fails++;
      $display("FAIL handoff d=%0d out_valid=%b in_ready=%b exp 0/1", d, out_valid[d], in_ready[d]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || sum[d] !== 8'h00 || cout[d] !== 1'b0) begin
        fails++;
        $display("FAIL reset d=%0d in_ready=%b out_valid=%b sum=%h cout=%b exp 1/0/00/0",
                 d, in_ready[d], out_valid[d], sum[d], cout[d]);
      end
`ifdef SERIAL_ADDER_SUB_EN
      tests++;
      if (overflow[d] !== 1'b0) begin
        fails++; $display("FAIL reset_overflow d=%0d got=%b exp=0", d, overflow[d]);
      end
`endif
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8, 0);
    run_op(1, 8'h3C, 8'h5A, 1'b1, 1'b0, 2, 0);
    run_op(0, 8'h00, 8'h00, 1'b0, 1'b0, 8, 0);
    run_op(1, 8'hFF, 8'hFF, 1'b1, 1'b0, 2, 0);
    run_op(0, 8'hA5, 8'h5A, 1'b1, 1'b0, 8, 0);
    run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 2, 0);
  endtask

  task automatic test_backpressure();
    run_op(0, 8'h12, 8'h34, 1'b1, 1'b0, 8, 5);
    run_op(1, 8'hC8, 8'h64, 1'b0, 1'b0, 2, 5);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    a[0] = 8'hFF; b[0] = 8'h00; cin[0] = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid[0] !== 1'b0 || sum[0] !== 8'h00 || cout[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_run out_valid=%b sum=%h cout=%b in_ready=%b exp 0/00/0/1",
               out_valid[0], sum[0], cout[0], in_ready[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 8'h10, 8'h20, 1'b0, 1'b0, 8, 0);
  endtask

  task automatic test_full_digit_random();
    for (int i = 0; i < 1000; i++)
      run_op(2, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1, 0);
  endtask

  task automatic test_sub();
    run_op(0, 8'h05, 8'h07, 1'b1, 1'b1, 8, 0);
    run_op(0, 8'h80, 8'h01, 1'b1, 1'b1, 8, 0);
    run_op(1, 8'h7F, 8'hFF, 1'b1, 1'b1, 2, 0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b1; cin[d] = 1'b0; a[d] = '0; b[d] = '0;
`ifdef SERIAL_ADDER_SUB_EN
      sub[d] = 1'b0;
`endif
    end
    test_reset();
    test_add();
    test_backpressure();
    test_reset_mid_run();
    test_full_digit_random();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
